// File: rtl/btn_event_ctrl.sv
// Debounced button controller: synchronizes and debounces each button, then queues
// press/release events in a small FIFO with overflow tracking and an interrupt.
module btn_event_ctrl #(
  parameter int NUM_BTNS        = 4,
  parameter int DEBOUNCE_CLOCKS = 10,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_low_in,
  input  logic [NUM_BTNS-1:0]           btn_in,
  input  logic                          evt_pop_in,
  input  logic                          irq_en_in,
  input  logic                          ovf_clr_in,
  output logic [NUM_BTNS-1:0]           btn_state_out,
  output logic                          evt_valid_out,
  output logic [$clog2(NUM_BTNS):0]     evt_data_out,
  output logic [$clog2(FIFO_DEPTH):0]   evt_count_out,
  output logic                          overflow_out,
  output logic                          irq_out
);

  localparam int IDX_W   = $clog2(NUM_BTNS);
  localparam int EVT_W   = IDX_W + 1;
  localparam int CNT_W   = $clog2(DEBOUNCE_CLOCKS + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int COUNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEBOUNCE_CLOCKS - 1);
  localparam logic [COUNT_W-1:0] COUNT_FULL = COUNT_W'(FIFO_DEPTH);

  logic [NUM_BTNS-1:0] sync1_reg;
  logic [NUM_BTNS-1:0] sync2_reg;
  logic [NUM_BTNS-1:0] stable_reg;
  logic [NUM_BTNS-1:0] change;
  logic [NUM_BTNS-1:0] pend_reg;
  logic [NUM_BTNS-1:0] ptype_reg;
  logic [NUM_BTNS-1:0] collide;
  logic [NUM_BTNS-1:0] push_onehot;

  logic [IDX_W-1:0]    push_idx;
  logic [EVT_W-1:0]    push_data;
  logic                push_en;
  logic                pop_en;
  logic                fifo_full;

  logic [EVT_W-1:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_reg;
  logic [PTR_W-1:0]    rd_ptr_reg;
  logic [COUNT_W-1:0]  count_reg;
  logic                ovf_reg;

  always_ff @(posedge clk_in or negedge rst_low_in) begin
    if (!rst_low_in) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= btn_in;
      sync2_reg <= sync1_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
      logic [CNT_W-1:0] cnt_reg;
      logic             stable_bit_reg;
      logic             pend_bit_reg;
      logic             ptype_bit_reg;
      logic             differ;

      assign differ         = sync2_reg[gi] ^ stable_bit_reg;
      assign change[gi]     = differ && (cnt_reg == CNT_LAST);
      assign stable_reg[gi] = stable_bit_reg;
      assign pend_reg[gi]   = pend_bit_reg;
      assign ptype_reg[gi]  = ptype_bit_reg;
      // A change landing on a still-pending event that is not leaving this cycle loses the older one.
      assign collide[gi]    = change[gi] && pend_bit_reg && !push_onehot[gi];

      always_ff @(posedge clk_in or negedge rst_low_in) begin
        if (!rst_low_in) begin
          cnt_reg        <= '0;
          stable_bit_reg <= 1'b0;
        end else if (!differ) begin
          cnt_reg <= '0;
        end else if (change[gi]) begin
          cnt_reg        <= '0;
          stable_bit_reg <= sync2_reg[gi];
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end

      always_ff @(posedge clk_in or negedge rst_low_in) begin
        if (!rst_low_in) begin
          pend_bit_reg  <= 1'b0;
          ptype_bit_reg <= 1'b0;
        end else if (change[gi]) begin
          pend_bit_reg  <= 1'b1;
          ptype_bit_reg <= sync2_reg[gi];
        end else if (push_onehot[gi]) begin
          pend_bit_reg <= 1'b0;
        end
      end
    end
  endgenerate

  assign fifo_full = (count_reg == COUNT_FULL);
  // Isolate the lowest set pending bit; nothing moves while the queue is full.
  assign push_onehot = fifo_full ? '0 : (pend_reg & (~pend_reg + NUM_BTNS'(1)));
  assign push_en     = |push_onehot;
  assign pop_en      = evt_pop_in && (count_reg != '0);

  always_comb begin
    push_idx = '0;
    for (int i = 0; i < NUM_BTNS; i++) begin
      if (push_onehot[i]) begin
        push_idx = IDX_W'(i);
      end
    end
  end

  assign push_data = {ptype_reg[push_idx], push_idx};

  always_ff @(posedge clk_in) begin
    if (push_en) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk_in or negedge rst_low_in) begin
    if (!rst_low_in) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop_en) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push_en, pop_en})
        2'b10:   count_reg <= count_reg + COUNT_W'(1);
        2'b01:   count_reg <= count_reg - COUNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_low_in) begin
    if (!rst_low_in) begin
      ovf_reg <= 1'b0;
    end else if (|collide) begin
      ovf_reg <= 1'b1;
    end else if (ovf_clr_in) begin
      ovf_reg <= 1'b0;
    end
  end

  assign btn_state_out = stable_reg;
  assign evt_valid_out = (count_reg != '0);
  assign evt_data_out  = mem[rd_ptr_reg];
  assign evt_count_out = count_reg;
  assign overflow_out  = ovf_reg;
  assign irq_out       = irq_en_in && evt_valid_out;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl: a queue-based event model is checked every cycle,
// with hand-computed literal expectations at the key points of each scenario.
module tb_btn_event_ctrl;

  localparam int NB    = 4;
  localparam int DEB   = 10;
  localparam int DEPTH = 4;

  logic          clk_in = 1'b0;
  logic          rst_low_in;
  logic [NB-1:0] btn_in;
  logic          evt_pop_in;
  logic          irq_en_in;
  logic          ovf_clr_in;
  logic [NB-1:0] btn_state_out;
  logic          evt_valid_out;
  logic [2:0]    evt_data_out;
  logic [2:0]    evt_count_out;
  logic          overflow_out;
  logic          irq_out;

  int tests = 0;
  int fails = 0;

  // Behavioural model: delayed raw levels, run lengths, pending slots and a queue.
  logic [NB-1:0] m_s1, m_s2, m_stable, m_pend, m_ptype;
  int            m_run [NB];
  logic [2:0]    m_fifo [$];
  logic          m_ovf;

  btn_event_ctrl #(.NUM_BTNS(NB), .DEBOUNCE_CLOCKS(DEB), .FIFO_DEPTH(DEPTH)) dut (
    .clk_in        (clk_in),
    .rst_low_in    (rst_low_in),
    .btn_in        (btn_in),
    .evt_pop_in    (evt_pop_in),
    .irq_en_in     (irq_en_in),
    .ovf_clr_in    (ovf_clr_in),
    .btn_state_out (btn_state_out),
    .evt_valid_out (evt_valid_out),
    .evt_data_out  (evt_data_out),
    .evt_count_out (evt_count_out),
    .overflow_out  (overflow_out),
    .irq_out       (irq_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_stable = '0; m_pend = '0; m_ptype = '0; m_ovf = 1'b0;
    for (int i = 0; i < NB; i++) m_run[i] = 0;
    m_fifo.delete();
  endtask

  task automatic model_step();
    logic [NB-1:0] chg, lvl, pend_old;
    int size_old, pj;
    logic [1:0] pidx;
    logic set_ovf;
    chg = '0;
    for (int i = 0; i < NB; i++) begin
      if (m_s2[i] == m_stable[i]) m_run[i] = 0;
      else if (m_run[i] == DEB - 1) begin chg[i] = 1'b1; m_run[i] = 0; end
      else m_run[i] = m_run[i] + 1;
    end
    lvl = m_s2;
    m_s2 = m_s1;
    m_s1 = btn_in;
    pend_old = m_pend;
    size_old = m_fifo.size();
    pj = -1;
    if (size_old < DEPTH)
      for (int i = NB - 1; i >= 0; i--) if (pend_old[i]) pj = i;
    if (evt_pop_in && size_old != 0) void'(m_fifo.pop_front());
    if (pj >= 0) begin
      pidx = pj[1:0];
      m_fifo.push_back({m_ptype[pj], pidx});
      m_pend[pj] = 1'b0;
    end
    set_ovf = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (chg[i]) begin
        if (pend_old[i] && pj != i) set_ovf = 1'b1;
        m_pend[i] = 1'b1;
        m_ptype[i] = lvl[i];
        m_stable[i] = lvl[i];
      end
    end
    if (set_ovf) m_ovf = 1'b1;
    else if (ovf_clr_in) m_ovf = 1'b0;
  endtask

  task automatic compare_cycle();
    check("btn_state", btn_state_out, m_stable);
    check("evt_count", evt_count_out, m_fifo.size());
    check("evt_valid", evt_valid_out, m_fifo.size() != 0);
    check("overflow", overflow_out, m_ovf);
    check("irq", irq_out, irq_en_in && (m_fifo.size() != 0));
    if (m_fifo.size() != 0) check("evt_data", evt_data_out, m_fifo[0]);
  endtask

  task automatic tick();
    @(posedge clk_in);
    if (!rst_low_in) model_reset();
    else model_step();
    @(negedge clk_in);
    compare_cycle();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic drain();
    evt_pop_in = 1'b1;
    for (int k = 0; k < 20 && m_fifo.size() != 0; k++) tick();
    evt_pop_in = 1'b0;
    check("drain_empty", evt_count_out, 0);
  endtask

  initial begin
    btn_in = '0; evt_pop_in = 1'b0; irq_en_in = 1'b1; ovf_clr_in = 1'b0;
    rst_low_in = 1'b0;
    model_reset();
    ticks(3);
    check("rst_state", btn_state_out, 0);
    check("rst_count", evt_count_out, 0);
    check("rst_irq", irq_out, 0);
    irq_en_in = 1'b0;
    rst_low_in = 1'b1;

    // Single press latency
    btn_in = 4'b0100;
    ticks(11);
    check("A_state_e11", btn_state_out, 4'b0000);
    tick();
    check("A_state_e12", btn_state_out, 4'b0100);
    check("A_valid_e12", evt_valid_out, 0);
    tick();
    check("A_valid_e13", evt_valid_out, 1);
    check("A_data_e13", evt_data_out, 3'b110);
    irq_en_in = 1'b1;
    #1 check("A_irq", irq_out, 1);
    irq_en_in = 1'b0;
    drain();
    btn_in = 4'b0000;
    ticks(13);
    check("A_release", evt_data_out, 3'b010);
    drain();

    // Nine-cycle glitch
    btn_in = 4'b0001;
    ticks(9);
    btn_in = 4'b0000;
    ticks(20);
    check("B_state", btn_state_out, 4'b0000);
    check("B_count", evt_count_out, 0);

    // Simultaneous presses: lower index first
    btn_in = 4'b1010;
    ticks(12);
    check("C_state", btn_state_out, 4'b1010);
    tick();
    check("C_count1", evt_count_out, 1);
    check("C_head1", evt_data_out, 3'b101);
    tick();
    check("C_count2", evt_count_out, 2);
    evt_pop_in = 1'b1;
    tick();
    evt_pop_in = 1'b0;
    check("C_head2", evt_data_out, 3'b111);
    drain();
    btn_in = 4'b0000;
    ticks(16);
    check("C_rel_count", evt_count_out, 2);
    check("C_rel_head", evt_data_out, 3'b001);
    drain();

    // Five events into a four-deep queue
    btn_in = 4'b1111;
    ticks(16);
    check("D_full", evt_count_out, 4);
    btn_in = 4'b1110;
    ticks(14);
    check("D_held", evt_count_out, 4);
    check("D_ovf", overflow_out, 0);
    evt_pop_in = 1'b1;
    tick();
    evt_pop_in = 1'b0;
    check("D_after_pop", evt_count_out, 3);
    check("D_head", evt_data_out, 3'b101);
    tick();
    check("D_refill", evt_count_out, 4);
    drain();

    // Overwrite of a held event sets overflow
    btn_in = 4'b0000;
    ticks(16);
    btn_in = 4'b1000;
    ticks(14);
    check("E_full", evt_count_out, 4);
    btn_in = 4'b1001;
    ticks(14);
    btn_in = 4'b1000;
    ticks(14);
    check("E_ovf_set", overflow_out, 1);
    evt_pop_in = 1'b1;
    tick();
    evt_pop_in = 1'b0;
    tick();
    evt_pop_in = 1'b1;
    ticks(3);
    evt_pop_in = 1'b0;
    check("E_last_count", evt_count_out, 1);
    check("E_last_data", evt_data_out, 3'b000);
    ovf_clr_in = 1'b1;
    tick();
    ovf_clr_in = 1'b0;
    check("E_ovf_clr", overflow_out, 0);
    drain();

    // Asynchronous reset with queued events
    btn_in = 4'b0100;
    ticks(16);
    irq_en_in = 1'b1;
    #1;
    check("F_irq_pre", irq_out, 1);
    check("F_count_pre", evt_count_out, 2);
    #1;
    rst_low_in = 1'b0;
    model_reset();
    #1;
    check("F_irq_rst", irq_out, 0);
    check("F_count_rst", evt_count_out, 0);
    check("F_state_rst", btn_state_out, 0);
    ticks(2);
    rst_low_in = 1'b1;
    irq_en_in = 1'b0;
    ticks(12);
    check("F_state_rel", btn_state_out, 4'b0100);
    tick();
    check("F_valid_rel", evt_valid_out, 1);
    check("F_data_rel", evt_data_out, 3'b110);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/btn_event_ctrl.md
BTN_EVENT_CTRL -- requirements
Module: btn_event_ctrl

Interface
REQ-001 SHALL have parameter NUM_BTNS, default 4: number of button inputs, range 2..16.
REQ-002 SHALL have parameter DEBOUNCE_CLOCKS, default 10: consecutive differing cycles required to accept a level change, minimum 1.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: event queue depth, power of two, minimum 2.
REQ-004 SHALL have port clk_in  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst_low_in  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port btn_in  input  NUM_BTNS  raw asynchronous button levels, bit i = button i.
REQ-007 SHALL have port evt_pop_in  input  1  consumer removes head event.
REQ-008 SHALL have port irq_en_in  input  1  interrupt enable.
REQ-009 SHALL have port ovf_clr_in  input  1  clears overflow flag.
REQ-010 SHALL have port btn_state_out  output  NUM_BTNS  debounced levels.
REQ-011 SHALL have port evt_valid_out  output  1  FIFO non-empty.
REQ-012 SHALL have port evt_data_out  output  1+$clog2(NUM_BTNS)  head event {press, index}: MSB 1 = press (0->1), 0 = release (1->0).
REQ-013 SHALL have port evt_count_out  output  $clog2(FIFO_DEPTH)+1  number of queued events.
REQ-014 SHALL have port overflow_out  output  1  sticky lost-event flag.
REQ-015 SHALL have port irq_out  output  1  interrupt request.

Function
REQ-016 SHALL pass each btn_in bit through a 2-flop synchronizer before any other logic.
REQ-017 SHALL keep one counter per button, width $clog2(DEBOUNCE_CLOCKS+1); it is cleared in any cycle where the synchronized level equals the stable level, and increments otherwise.
REQ-018 SHALL update the stable bit to the synchronized level, and clear the counter, on the edge where the counter equals DEBOUNCE_CLOCKS-1 and the levels still differ; btn_state_out therefore changes at the (DEBOUNCE_CLOCKS+2)th rising edge after a clean btn_in transition.
REQ-019 SHALL discard glitches shorter than DEBOUNCE_CLOCKS synchronized cycles, with no stable change and no event.
REQ-020 SHALL set pending[i] and record its type (press/release) on the same edge as any stable change of button i.
REQ-021 SHALL, each cycle that any pending bit is set and evt_count_out < FIFO_DEPTH (pre-edge value), push the lowest-index pending event and clear that pending bit on the same edge; at most one push per cycle.
REQ-022 SHALL block push when the FIFO is full, even if evt_pop_in is asserted in the same cycle; pending events are held, not dropped.
REQ-023 SHALL, on a stable change of button i while pending[i] is set and not being pushed that cycle, overwrite the pending type with the newer type and set overflow_out.
REQ-024 SHALL hold overflow_out until ovf_clr_in is sampled high; if set and clear coincide, set wins.
REQ-025 SHALL present the FIFO head on evt_data_out whenever evt_valid_out is 1; evt_data_out is don't-care when empty.
REQ-026 SHALL remove the head on an edge with evt_pop_in=1 and evt_valid_out=1; pop on empty is ignored with no state change.
REQ-027 SHALL handle simultaneous push and pop when not full with evt_count_out unchanged, and keep event order strictly FIFO.
REQ-028 SHALL implement FIFO read/write pointers that wrap modulo FIFO_DEPTH.
REQ-029 SHALL drive evt_valid_out = (evt_count_out != 0) and irq_out = irq_en_in AND evt_valid_out, combinationally from registered state.
REQ-030 SHALL make an event visible on evt_valid_out one edge after the stable change when the FIFO has space and no lower-index button is pending.

Reset
REQ-031 SHALL, while rst_low_in is 0, clear synchronizers, counters, stable bits, pending bits, FIFO pointers and count, and overflow; btn_state_out=0, evt_valid_out=0, evt_count_out=0, overflow_out=0, irq_out=0.
REQ-032 SHALL discard all queued and pending events on reset assertion mid-operation; a button held high through reset release produces a press event after the normal debounce latency.

Verification
REQ-033 SHALL verify: DEBOUNCE_CLOCKS=10, btn_in[2] 0->1 held -> btn_state_out[2]=1 at edge 12, evt_valid_out=1 after edge 13, evt_data_out={1,2'd2}.
REQ-034 SHALL verify: 9-cycle pulse on btn_in[0] -> no btn_state_out change, evt_count_out stays 0.
REQ-035 SHALL verify: btn_in[3] and btn_in[1] rise in the same cycle -> events queued as index 1 then index 3 on consecutive edges.
REQ-036 SHALL verify: FIFO_DEPTH=4, 5 events without pops -> evt_count_out=4, 5th held pending, pushed the edge after the first pop; overflow_out stays 0.
REQ-037 SHALL verify: full FIFO, button 0 pressed then released before push -> overflow_out=1, queued entry is release; ovf_clr_in pulse -> overflow_out=0.
REQ-038 SHALL verify: irq_en_in=1 with 2 queued events, reset asserted -> irq_out=0 and evt_count_out=0 immediately, without waiting for a clock edge.
